apb_master_arbiter: RTL

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_master_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter that shares one APB master port
// among NUM_REQ requesters. Each grant runs a full SETUP/ACCESS transfer and
// returns a one-cycle done pulse with the read data and error status.
// Optional feature: define APB_ARB_TIMEOUT_EN to bound ACCESS wait states
// to TIMEOUT_CYCLES. A timed-out transfer completes with rsp_err=1.
module apb_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int PDATA_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              PCLK,
    input  logic                              PRESETn,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*PDATA_SIZE-1:0]     req_addr,
    input  logic [NUM_REQ*PDATA_SIZE-1:0]     req_wdata,
    input  logic [NUM_REQ*PDATA_SIZE/8-1:0]   req_strb,
    output logic [NUM_REQ-1:0]                done,
    output logic [PDATA_SIZE-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic                              PSEL,
    output logic                              PENABLE,
    output logic                              PWRITE,
    output logic [PDATA_SIZE-1:0]             PADDR,
    output logic [PDATA_SIZE-1:0]             PWDATA,
    output logic [PDATA_SIZE/8-1:0]           PSTRB,
    output logic [2:0]                        PPROT,
    input  logic [PDATA_SIZE-1:0]             PRDATA,
    input  logic                              PREADY,
    input  logic                              PSLVERR
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = PDATA_SIZE / 8;

    // Parameter sanity checks at elaboration time.
    if ((NUM_REQ < 2) || (NUM_REQ > 8) || ((PDATA_SIZE % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("apb_master_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [GW-1:0]          r_grant;
    logic [GW-1:0]          r_last_grant;
    logic [NUM_REQ-1:0]     r_done;
    logic [PDATA_SIZE-1:0]  r_rdata;
    logic                   r_err;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [PDATA_SIZE-1:0]  r_paddr;
    logic [PDATA_SIZE-1:0]  r_pwdata;
    logic [SW-1:0]          r_pstrb;

    logic [NUM_REQ-1:0]     w_grant_oh;
    logic [NUM_REQ-1:0]     w_cand;
    logic                   w_found;
    logic [GW-1:0]          w_win;
    logic [GW-1:0]          w_idx;
    logic                   w_complete;
    logic                   w_load;
    logic                   w_timeout;
    logic                   w_sel_write;
    logic [PDATA_SIZE-1:0]  w_sel_addr;
    logic [PDATA_SIZE-1:0]  w_sel_wdata;
    logic [SW-1:0]          w_sel_strb;

    assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
    assign w_complete = (r_state == ST_ACCESS) && (PREADY || w_timeout);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_to_cnt;

    assign w_timeout = (r_state == ST_ACCESS) && !PREADY &&
                       (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count consecutive stalled ACCESS cycles; cleared on completion and outside ACCESS.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_to_cnt <= {CW{1'b0}};
        end else if ((r_state == ST_ACCESS) && !PREADY && !w_timeout) begin
            r_to_cnt <= r_to_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_to_cnt <= {CW{1'b0}};
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Round-robin winner search starting after last_grant; the completing requester is excluded.
    always_comb begin
        w_cand      = req;
        w_found     = 1'b0;
        w_win       = {GW{1'b0}};
        w_idx       = {GW{1'b0}};
        w_sel_write = 1'b0;
        w_sel_addr  = {PDATA_SIZE{1'b0}};
        w_sel_wdata = {PDATA_SIZE{1'b0}};
        w_sel_strb  = {SW{1'b0}};
        if (w_complete) begin
            w_cand = req & ~w_grant_oh;
        end else begin
            w_cand = req;
        end
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == GW'(i)) begin
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*PDATA_SIZE +: PDATA_SIZE];
                w_sel_wdata = req_wdata[i*PDATA_SIZE +: PDATA_SIZE];
                w_sel_strb  = req_strb[i*SW +: SW];
            end else begin
                w_sel_write = w_sel_write;
            end
        end
    end

    // Next-state decode for the IDLE/SETUP/ACCESS transfer sequence.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_SETUP;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_complete && w_found) begin
                    w_next_state = ST_SETUP;
                    w_load       = 1'b1;
                end else if (w_complete) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ACCESS;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register with registered PSEL/PENABLE decoded from the next state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_psel    <= (w_next_state != ST_IDLE);
            r_penable <= (w_next_state == ST_ACCESS);
        end
    end

    // Latch the winner's request fields onto the bus; they hold until the next grant.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_grant      <= {GW{1'b0}};
            r_last_grant <= GW'(NUM_REQ - 1);
            r_pwrite     <= 1'b0;
            r_paddr      <= {PDATA_SIZE{1'b0}};
            r_pwdata     <= {PDATA_SIZE{1'b0}};
            r_pstrb      <= {SW{1'b0}};
        end else if (w_load) begin
            r_grant      <= w_win;
            r_last_grant <= w_win;
            r_pwrite     <= w_sel_write;
            r_paddr      <= w_sel_addr;
            r_pwdata     <= w_sel_wdata;
            r_pstrb      <= w_sel_write ? w_sel_strb : {SW{1'b0}};
        end else begin
            r_grant      <= r_grant;
            r_last_grant <= r_last_grant;
        end
    end

    // Completion response: one-cycle done pulse plus read data and error status.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_done  <= {NUM_REQ{1'b0}};
            r_rdata <= {PDATA_SIZE{1'b0}};
            r_err   <= 1'b0;
        end else if (w_complete) begin
            r_done  <= w_grant_oh;
            r_rdata <= (r_pwrite || w_timeout) ? {PDATA_SIZE{1'b0}} : PRDATA;
            r_err   <= w_timeout ? 1'b1 : PSLVERR;
        end else begin
            r_done  <= {NUM_REQ{1'b0}};
        end
    end

    assign done      = r_done;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PPROT     = 3'b000;

endmodule
